// File: rtl/lda_pkg.sv
// Shared definitions for the line-drawing accelerator.
//   - Avalon register word addresses
//   - FSM state encoding
//   - bit positions of the x/y fields in the START/END registers
package lda_pkg;

  localparam logic [2:0] ADDR_MODE   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_GO     = 3'd2;
  localparam logic [2:0] ADDR_START  = 3'd3;
  localparam logic [2:0] ADDR_END    = 3'd4;
  localparam logic [2:0] ADDR_COLOUR = 3'd5;

  localparam int unsigned POS_X_LSB = 0;
  localparam int unsigned POS_Y_LSB = 16;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StDraw,
    StDone
  } lda_state_e;

  function automatic int unsigned max_w(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lda_bresenham_step.sv
// Combinational Bresenham step: from the current point and error term,
// produce the next point and error, and flag when the current point is the
// line end.
//   cur_x_i/cur_y_i   current point
//   end_x_i/end_y_i   latched line end point
//   err_i             signed error term
//   dx_i/dy_i         absolute deltas (non-negative, signed container)
//   sx_neg_i/sy_neg_i step direction is -1 when set
//   nxt_*_o           point and error after one step
//   at_end_o          current point equals the end point
module lda_bresenham_step #(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 8,
  parameter int unsigned E_W = 11
) (
  input  logic [X_W-1:0]        cur_x_i,
  input  logic [Y_W-1:0]        cur_y_i,
  input  logic [X_W-1:0]        end_x_i,
  input  logic [Y_W-1:0]        end_y_i,
  input  logic signed [E_W-1:0] err_i,
  input  logic signed [E_W-1:0] dx_i,
  input  logic signed [E_W-1:0] dy_i,
  input  logic                  sx_neg_i,
  input  logic                  sy_neg_i,
  output logic [X_W-1:0]        nxt_x_o,
  output logic [Y_W-1:0]        nxt_y_o,
  output logic signed [E_W-1:0] nxt_err_o,
  output logic                  at_end_o
);

  // 2*err needs one bit more than err itself
  logic signed [E_W:0]   e2;
  logic signed [E_W:0]   dx_ext;
  logic signed [E_W:0]   dy_ext;
  logic                  step_x;
  logic                  step_y;
  logic signed [E_W-1:0] err_x;

  always_comb begin
    e2        = {err_i, 1'b0};
    dx_ext    = {dx_i[E_W-1], dx_i};
    dy_ext    = {dy_i[E_W-1], dy_i};
    step_x    = (e2 >= -dy_ext);
    step_y    = (e2 <= dx_ext);
    err_x     = step_x ? (err_i - dy_i) : err_i;
    nxt_err_o = step_y ? (err_x + dx_i) : err_x;

    nxt_x_o = cur_x_i;
    if (step_x) begin
      nxt_x_o = sx_neg_i ? (cur_x_i - X_W'(1)) : (cur_x_i + X_W'(1));
    end
    nxt_y_o = cur_y_i;
    if (step_y) begin
      nxt_y_o = sy_neg_i ? (cur_y_i - Y_W'(1)) : (cur_y_i + Y_W'(1));
    end

    at_end_o = (cur_x_i == end_x_i) && (cur_y_i == end_y_i);
  end

endmodule

// File: rtl/lda_engine_param.sv
// Parametrised line-drawing accelerator: Avalon-MM register file, control FSM
// and a valid/ready pixel stream that emits one Bresenham point per cycle.
//   clk, reset            clock, synchronous active-high reset
//   avs_*                 Avalon-MM slave (read latency 0, waitrequest in stall mode)
//   pix_x/pix_y/pix_colour pixel presented to the framebuffer
//   pix_valid/pix_ready   pixel handshake; off-screen points never assert valid
module lda_engine_param
  import lda_pkg::*;
#(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 24,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                avs_waitrequest,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_valid,
  input  logic                pix_ready
);

  localparam int unsigned E_W = max_w(X_W, Y_W) + 2;

  // Register file
  logic                mode_q;
  logic [X_W-1:0]      start_x_q, end_x_q;
  logic [Y_W-1:0]      start_y_q, end_y_q;
  logic [COLOUR_W-1:0] colour_q;

  // Line engine state
  lda_state_e            state_q, state_d;
  logic [X_W-1:0]        cur_x_q, cur_x_d, lend_x_q, lend_x_d;
  logic [Y_W-1:0]        cur_y_q, cur_y_d, lend_y_q, lend_y_d;
  logic [COLOUR_W-1:0]   lcol_q, lcol_d;
  logic signed [E_W-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic                  go_wr;
  logic                  clipped;
  logic                  step;
  logic signed [E_W-1:0] diff_x, diff_y;
  logic [X_W-1:0]        nxt_x;
  logic [Y_W-1:0]        nxt_y;
  logic signed [E_W-1:0] nxt_err;
  logic                  at_end;

  // Reads are side-effect free and only some write-data bits are stored.
  logic unused_sigs;
  assign unused_sigs = ^{avs_read, avs_writedata};

  assign go_wr   = avs_write && (avs_address == ADDR_GO);
  assign clipped = (32'(cur_x_q) >= SCREEN_W) || (32'(cur_y_q) >= SCREEN_H);
  // Off-screen points advance without a handshake.
  assign step    = (state_q == StDraw) && (clipped || pix_ready);

  assign pix_valid  = (state_q == StDraw) && !clipped;
  assign pix_x      = cur_x_q;
  assign pix_y      = cur_y_q;
  assign pix_colour = lcol_q;

  // Stall mode holds the GO write until the line reaches DONE.
  assign avs_waitrequest = !mode_q && go_wr && (state_q != StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 1'b0;
      start_x_q <= '0;
      start_y_q <= '0;
      end_x_q   <= '0;
      end_y_q   <= '0;
      colour_q  <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_MODE: mode_q <= avs_writedata[0];
        ADDR_START: begin
          start_x_q <= avs_writedata[POS_X_LSB +: X_W];
          start_y_q <= avs_writedata[POS_Y_LSB +: Y_W];
        end
        ADDR_END: begin
          end_x_q <= avs_writedata[POS_X_LSB +: X_W];
          end_y_q <= avs_writedata[POS_Y_LSB +: Y_W];
        end
        ADDR_COLOUR: colour_q <= avs_writedata[COLOUR_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      ADDR_MODE:   avs_readdata[0] = mode_q;
      ADDR_STATUS: avs_readdata[0] = (state_q != StIdle);
      ADDR_START: begin
        avs_readdata[POS_X_LSB +: X_W] = start_x_q;
        avs_readdata[POS_Y_LSB +: Y_W] = start_y_q;
      end
      ADDR_END: begin
        avs_readdata[POS_X_LSB +: X_W] = end_x_q;
        avs_readdata[POS_Y_LSB +: Y_W] = end_y_q;
      end
      ADDR_COLOUR: avs_readdata[COLOUR_W-1:0] = colour_q;
      default: ;
    endcase
  end

  lda_bresenham_step #(
    .X_W(X_W),
    .Y_W(Y_W),
    .E_W(E_W)
  ) u_step (
    .cur_x_i  (cur_x_q),
    .cur_y_i  (cur_y_q),
    .end_x_i  (lend_x_q),
    .end_y_i  (lend_y_q),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .nxt_x_o  (nxt_x),
    .nxt_y_o  (nxt_y),
    .nxt_err_o(nxt_err),
    .at_end_o (at_end)
  );

  always_comb begin
    diff_x = $signed(E_W'(end_x_q)) - $signed(E_W'(start_x_q));
    diff_y = $signed(E_W'(end_y_q)) - $signed(E_W'(start_y_q));

    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    lend_x_d = lend_x_q;
    lend_y_d = lend_y_q;
    lcol_d   = lcol_q;
    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    unique case (state_q)
      StIdle: begin
        if (go_wr) state_d = StInit;
      end
      StInit: begin
        // Register writes landing this same cycle are not seen here.
        cur_x_d  = start_x_q;
        cur_y_d  = start_y_q;
        lend_x_d = end_x_q;
        lend_y_d = end_y_q;
        lcol_d   = colour_q;
        dx_d     = diff_x[E_W-1] ? -diff_x : diff_x;
        dy_d     = diff_y[E_W-1] ? -diff_y : diff_y;
        err_d    = dx_d - dy_d;
        sx_neg_d = diff_x[E_W-1];
        sy_neg_d = diff_y[E_W-1];
        state_d  = StDraw;
      end
      StDraw: begin
        if (step) begin
          if (at_end) begin
            state_d = StDone;
          end else begin
            cur_x_d = nxt_x;
            cur_y_d = nxt_y;
            err_d   = nxt_err;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      lend_x_q <= '0;
      lend_y_q <= '0;
      lcol_q   <= '0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      lend_x_q <= lend_x_d;
      lend_y_q <= lend_y_d;
      lcol_q   <= lcol_d;
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule

// File: tb/tb_lda_engine_param.sv
module tb_lda_engine_param;
  import lda_pkg::*;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 24;
  localparam int SW = 320;
  localparam int SH = 240;

  logic          clk;
  logic          reset;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_colour;
  logic          pix_valid;
  logic          pix_ready;

  lda_engine_param #(
    .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_colour     (pix_colour),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference line: textbook Bresenham over integers, off-screen points dropped.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input int c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx - dy;
    x   = x0;
    y   = y0;
    while (1) begin
      if (x < SW && y < SH) sb_q.push_back('{x, y, c});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Pixel ready driver
  initial begin
    int rcnt = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (ready_mode)
        1:       pix_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        2:       pix_ready = ($urandom_range(0, 9) < 7);
        default: pix_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted pixel, checks hold under backpressure
  initial begin
    pix_t e;
    logic prev_stall;
    int   px, py, pc;
    prev_stall = 1'b0;
    px = 0; py = 0; pc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", longint'(pix_valid), 1);
          chk("hold_x", longint'(pix_x), px);
          chk("hold_y", longint'(pix_y), py);
          chk("hold_colour", longint'(pix_colour), pc);
        end
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) expected no pixel", pix_x, pix_y);
          end else begin
            e = sb_q.pop_front();
            if (pix_x !== XW'(e.x) || pix_y !== YW'(e.y) || pix_colour !== CW'(e.c)) begin
              errors++;
              $display("FAIL pixel: got (%0d,%0d,%06h) expected (%0d,%0d,%06h)",
                       pix_x, pix_y, pix_colour, e.x, e.y, e.c);
            end
          end
        end
        prev_stall = (pix_valid === 1'b1) && (pix_ready === 1'b0);
        px = int'(pix_x);
        py = int'(pix_y);
        pc = int'(pix_colour);
      end
    end
  end

  function automatic logic [31:0] pack(input int x, input int y);
    return 32'((y << 16) | x);
  endfunction

  // All bus tasks start and end just after a rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b0;
    @(negedge clk);
    while (avs_waitrequest && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wr_timeout: got waitrequest stuck expected release");
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    d = avs_readdata;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    avs_address = ADDR_STATUS; avs_read = 1'b1;
    @(negedge clk);
    while (avs_readdata[0] && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic go_count(output int n);
    wr(ADDR_GO, 32'd0);
    avs_address = ADDR_STATUS; avs_read = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!avs_readdata[0]) break;
      n++;
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic setup_line(input int x0, input int y0, input int x1, input int y1,
                            input int c);
    wr(ADDR_START, pack(x0, y0));
    wr(ADDR_END, pack(x1, y1));
    wr(ADDR_COLOUR, 32'(c));
    model_line(x0, y0, x1, y1, c);
  endtask

  task automatic check_regs_reset(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("%s_reg%0d", tag, a), longint'(d), 0);
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", longint'(pix_valid), 0);
    chk("rst_x", longint'(pix_x), 0);
    chk("rst_y", longint'(pix_y), 0);
    chk("rst_colour", longint'(pix_colour), 0);
    chk("rst_wait", longint'(avs_waitrequest), 0);
    @(posedge clk); #1;
    check_regs_reset("rst");

    // Poll mode horizontal line, exact cycle timing
    wr(ADDR_MODE, 32'd1);
    setup_line(10, 20, 15, 20, 'hFF0000);
    wr(ADDR_GO, 32'd0);
    avs_address = ADDR_STATUS; avs_read = 1'b1;
    @(negedge clk);
    chk("t1_init_valid", longint'(pix_valid), 0);
    chk("t1_init_busy", longint'(avs_readdata[0]), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t1_valid%0d", i), longint'(pix_valid), 1);
      chk($sformatf("t1_busy%0d", i), longint'(avs_readdata[0]), 1);
    end
    @(negedge clk);
    chk("t1_done_valid", longint'(pix_valid), 0);
    chk("t1_done_busy", longint'(avs_readdata[0]), 1);
    @(negedge clk);
    chk("t1_idle_busy", longint'(avs_readdata[0]), 0);
    @(posedge clk); #1;
    avs_read = 1'b0;
    chk("t1_drain", sb_q.size(), 0);

    // Stall mode: GO held through IDLE, INIT and 8 DRAW cycles
    wr(ADDR_MODE, 32'd0);
    setup_line(0, 0, 3, 7, 'h00FF00);
    avs_address = ADDR_GO; avs_writedata = '0; avs_write = 1'b1;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 100) begin n++; @(negedge clk); end
    chk("t2_wait_cycles", n, 10);
    @(posedge clk); #1;
    avs_write = 1'b0;
    wait_idle();
    chk("t2_drain", sb_q.size(), 0);

    // Single point, then negative-direction line
    wr(ADDR_MODE, 32'd1);
    setup_line(5, 5, 5, 5, 'h123456);
    go_count(n);
    chk("t3_busy_point", n, 3);
    chk("t3_drain_point", sb_q.size(), 0);
    setup_line(8, 8, 2, 3, 'h654321);
    go_count(n);
    chk("t3_busy_neg", n, 9);
    chk("t3_drain_neg", sb_q.size(), 0);

    // Diagonal under 1,0,0,1 backpressure
    ready_mode = 1;
    setup_line(0, 0, 4, 4, 'hABCDEF);
    wr(ADDR_GO, 32'd0);
    wait_idle();
    ready_mode = 0;
    chk("t4_drain", sb_q.size(), 0);

    // Right-edge clipping
    setup_line(318, 0, 322, 0, 'h0000FF);
    go_count(n);
    chk("t5_busy_clip", n, 7);
    chk("t5_drain", sb_q.size(), 0);

    // Second GO and END rewrite mid-line do not disturb the running line
    setup_line(0, 0, 20, 10, 'h777777);
    wr(ADDR_GO, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    wr(ADDR_GO, 32'd0);
    wr(ADDR_END, pack(5, 5));
    wait_idle();
    rd(ADDR_END, d);
    chk("t6_end_reg", longint'(d), longint'(pack(5, 5)));
    repeat (3) begin @(posedge clk); #1; end
    rd(ADDR_STATUS, d);
    chk("t6_no_restart", longint'(d), 0);
    chk("t6_drain", sb_q.size(), 0);

    // Reset mid-line
    setup_line(0, 0, 30, 0, 'h0F0F0F);
    wr(ADDR_GO, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_valid", longint'(pix_valid), 0);
    chk("t7_x", longint'(pix_x), 0);
    chk("t7_colour", longint'(pix_colour), 0);
    @(posedge clk); #1;
    check_regs_reset("t7");
    chk("t7_drain", sb_q.size(), 0);

    // Random lines under random backpressure, including off-screen spans
    wr(ADDR_MODE, 32'd1);
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      setup_line(int'($urandom_range(0, 340)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 340)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 'hFFFFFF)));
      wr(ADDR_GO, 32'd0);
      wait_idle();
      chk($sformatf("rand%0d_drain", i), sb_q.size(), 0);
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
